// File: rtl/cios_tstore_seq.sv
// CIOS accumulator store and row sequencer.
// Holds T[0..S+1] for one Montgomery multiplication and runs S row passes of
// the external row engine. It commits the engine's write stream into T, checks
// each row's write count, and streams T[0..S-1] out over valid/ready.
module cios_tstore_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned S       = 8,
    parameter int unsigned W_ROW   = 2 * S + 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    output logic                       busy,
    output logic [$clog2(S)-1:0]       a_idx,
    output logic                       row_start,
    output logic                       row_flush,
    input  logic                       row_we,
    input  logic [$clog2(S+2)-1:0]     row_waddr,
    input  logic [WIDTH-1:0]           row_wdata,
    input  logic                       row_done,
    output logic [WIDTH-1:0]           T [S+2],
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(S)-1:0]       res_idx,
    output logic                       res_last,
    output logic [WIDTH-1:0]           res_msw,
    output logic                       err
);

    localparam int unsigned IW = $clog2(S);
    localparam int unsigned AW = $clog2(S + 2);
    localparam int unsigned CW = $clog2(W_ROW + 2);
    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [AW-1:0] MAX_ADDR = AW'(S + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);
    localparam logic [CW-1:0] WCNT_EXP = CW'(W_ROW);
    localparam logic [CW-1:0] WCNT_SAT = CW'(W_ROW + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRowStart,
        StRowWait,
        StRowCheck,
        StErrAbort,
        StDrain
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_t [S+2];
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_res_idx;
    logic [CW-1:0]    r_wcnt;
    logic [TW-1:0]    r_tmo;
    logic             r_err;

    logic             w_addr_ok;
    logic             w_wr_en;
    logic             w_err_set;
    logic             w_err_clr;
    logic             w_row_adv;
    logic             w_drain_enter;
    logic             w_res_adv;

    assign w_addr_ok = (row_waddr <= MAX_ADDR);

    // Next-state decode and datapath enables; the bad-address check wins over
    // completion and timeout so a stray write never reaches T.
    always_comb begin
        w_state_next  = r_state;
        w_wr_en       = 1'b0;
        w_err_set     = 1'b0;
        w_err_clr     = 1'b0;
        w_row_adv     = 1'b0;
        w_drain_enter = 1'b0;
        w_res_adv     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (go) begin
                    w_state_next = StClear;
                    w_err_clr    = 1'b1;
                end
            end
            StClear:    w_state_next = StRowStart;
            StRowStart: w_state_next = StRowWait;
            StRowWait: begin
                if (row_we && !w_addr_ok) begin
                    w_err_set    = 1'b1;
                    w_state_next = StErrAbort;
                end else begin
                    w_wr_en = row_we;
                    if (row_done) begin
                        w_state_next = StRowCheck;
                    end else if (r_tmo == TMO_LAST) begin
                        w_err_set    = 1'b1;
                        w_state_next = StErrAbort;
                    end
                end
            end
            StRowCheck: begin
                if (r_wcnt != WCNT_EXP) begin
                    w_err_set    = 1'b1;
                    w_state_next = StErrAbort;
                end else if (r_i == LAST_IDX) begin
                    w_drain_enter = 1'b1;
                    w_state_next  = StDrain;
                end else begin
                    w_row_adv    = 1'b1;
                    w_state_next = StRowStart;
                end
            end
            StErrAbort: w_state_next = StIdle;
            StDrain: begin
                if (res_ready) begin
                    if (r_res_idx == LAST_IDX) begin
                        w_state_next = StIdle;
                    end else begin
                        w_res_adv = 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accumulator register file: cleared per multiplication, single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < S + 2; k++) begin
                r_t[k] <= '0;
            end
        end else if (r_state == StClear) begin
            for (int k = 0; k < S + 2; k++) begin
                r_t[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_t[row_waddr] <= row_wdata;
        end
    end

    // Row index, which doubles as the operand word select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
        end else if (r_state == StClear) begin
            r_i <= '0;
        end else if (w_row_adv) begin
            r_i <= r_i + IW'(1);
        end
    end

    // Per-row write counter; saturates just past the expected count so a
    // runaway engine cannot wrap back onto a matching value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (r_state == StClear || r_state == StRowStart) begin
            r_wcnt <= '0;
        end else if (w_wr_en && r_wcnt != WCNT_SAT) begin
            r_wcnt <= r_wcnt + CW'(1);
        end
    end

    // Cycles spent waiting on the row engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == StRowStart) begin
            r_tmo <= '0;
        end else if (r_state == StRowWait && r_tmo != TMO_LAST) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Sticky error flag, cleared only by an accepted go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    // Result word pointer; holds at S-1 after the last handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_idx <= '0;
        end else if (w_drain_enter) begin
            r_res_idx <= '0;
        end else if (w_res_adv) begin
            r_res_idx <= r_res_idx + IW'(1);
        end
    end

    assign busy      = (r_state != StIdle);
    assign row_start = (r_state == StRowStart);
    assign row_flush = (r_state == StErrAbort);
    assign res_valid = (r_state == StDrain);
    assign res_last  = res_valid && (r_res_idx == LAST_IDX);
    assign res_idx   = r_res_idx;
    assign res_data  = r_t[AW'(r_res_idx)];
    assign res_msw   = r_t[S];
    assign a_idx     = r_i;
    assign err       = r_err;
    assign T         = r_t;

endmodule
